duty_ramp_ctrl: RTL and testbench
=================================

DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter BITS, 8, width of duty values (matches PWM counter width).
REQ-002 SHALL have parameter DUTY_MAX, 8'd250, ceiling for duty output (matches PWM period).
REQ-003 SHALL have parameter STEP, 1, duty increment/decrement per ramp tick (1..DUTY_MAX).
REQ-004 SHALL have parameter TICK_DIV, 16'd50000, clk cycles per ramp tick (>=1).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tgt_valid  input  1  new target duty offered.
REQ-008 SHALL have port tgt_ready  output  1  block accepts target this cycle.
REQ-009 SHALL have port tgt_duty  input  BITS  requested duty.
REQ-010 SHALL have port estop  input  1  emergency stop, level-sensitive.
REQ-011 SHALL have port fault_clr  input  1  request to leave FAULT.
REQ-012 SHALL have port duty_cycle  output  BITS  registered duty fed to PWM duty_cycle.
REQ-013 SHALL have ports busy, at_target, fault  output  1 each  status flags.

Function
REQ-014 SHALL implement states IDLE, UP, DOWN, FAULT; busy=(UP|DOWN), at_target=IDLE, fault=FAULT, all registered-state decodes.
REQ-015 SHALL drive tgt_ready=1 in every state except FAULT; accept = tgt_valid & tgt_ready.
REQ-016 On accept SHALL latch target = min(tgt_duty, DUTY_MAX) and, next cycle, enter UP if target>duty_cycle, DOWN if target<duty_cycle, else IDLE; accepts allowed in UP/DOWN (retarget, direction re-evaluated).
REQ-017 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, assert one-cycle tick at TICK_DIV-1; cleared to 0 on every accept; TICK_DIV=1 ticks every cycle.
REQ-018 On accept cycle no duty step SHALL occur, even if tick coincides; first step at accept+TICK_DIV cycles.
REQ-019 In UP on tick SHALL set duty_cycle = min(duty+STEP, target), computed in BITS+1 bits (no wrap); reaching target -> IDLE same edge.
REQ-020 In DOWN on tick SHALL set duty_cycle = target if duty-target<=STEP else duty-STEP, computed without underflow; reaching target -> IDLE.
REQ-021 duty_cycle SHALL only change on tick or entry to FAULT; IDLE holds value indefinitely.
REQ-022 estop=1 SHALL have highest priority: any state -> FAULT next edge, duty_cycle=0 and target=0 same edge, tgt_valid ignored.
REQ-023 FAULT SHALL exit to IDLE only when fault_clr=1 and estop=0 in same cycle; duty_cycle stays 0; fault_clr outside FAULT ignored.
REQ-024 duty_cycle SHALL never exceed DUTY_MAX in any state.

Reset
REQ-025 reset=1 at clk edge SHALL force state IDLE, duty_cycle=0, target=0, tick counter=0; outputs after: tgt_ready=1, at_target=1, busy=0, fault=0.
REQ-026 reset SHALL override estop and any ramp in progress; estop still high after reset release -> FAULT next edge.

Structure
REQ-027 State encoding and default DUTY_MAX SHALL live in shared package autoclave_pwm_pkg.
REQ-028 Tick counter SHALL be sub-module ramp_tick_gen (params TICK_DIV; ports clk, reset, clr, tick).

Verification
REQ-029 Reset: reset high 2 cycles, estop=0 -> duty_cycle=0, tgt_ready=1, at_target=1, fault=0.
REQ-030 Ramp up: TICK_DIV=4, STEP=1, accept 10 from 0 -> duty +1 every 4 cycles, duty=10 and at_target=1 at accept+40.
REQ-031 Clamp: DUTY_MAX=250, STEP=7, TICK_DIV=1, accept 255 -> duty 7,14..245, then 250, IDLE; never >250.
REQ-032 Retarget: ramp to 100, accept 20 when duty=40 -> DOWN, duty decreases to exactly 20, IDLE.
REQ-033 Underflow: duty=5, STEP=7, accept 0 -> one tick later duty=0, IDLE, no wrap to 254.
REQ-034 Estop: estop at duty=60 mid-UP -> next edge duty=0, fault=1, tgt_ready=0; fault_clr with estop=1 stays FAULT; fault_clr with estop=0 -> IDLE, duty=0.

Source files
------------

// File: rtl/autoclave_pwm_pkg.sv
// Shared definitions for the autoclave PWM duty path: ramp FSM state encoding
// and the default duty ceiling matching the PWM period.
package autoclave_pwm_pkg;

    localparam int unsigned DUTY_BITS_DEFAULT = 8;
    localparam int unsigned DUTY_MAX_DEFAULT  = 250;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_FAULT = 2'd3
    } ramp_state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp pacing counter: counts 0..TICK_DIV-1 and flags the last count as a
// one-cycle tick. clr restarts the period so a new target gets a full interval.
module ramp_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Duty ramp controller: slews the PWM duty toward an accepted target by STEP
// every TICK_DIV cycles, clamped to DUTY_MAX, with an estop-driven FAULT state.
module duty_ramp_ctrl
    import autoclave_pwm_pkg::*;
#(
    parameter int unsigned BITS     = DUTY_BITS_DEFAULT,
    parameter int unsigned DUTY_MAX = DUTY_MAX_DEFAULT,
    parameter int unsigned STEP     = 1,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tgt_valid,
    output logic            tgt_ready,
    input  logic [BITS-1:0] tgt_duty,
    input  logic            estop,
    input  logic            fault_clr,
    output logic [BITS-1:0] duty_cycle,
    output logic            busy,
    output logic            at_target,
    output logic            fault
);

    localparam int unsigned W = BITS + 1;
    localparam logic [BITS-1:0] DMAX = BITS'(DUTY_MAX);

    ramp_state_e     state_q, state_nxt;
    logic [BITS-1:0] target_q;
    logic [BITS-1:0] tgt_clamped;
    logic            accept;
    logic            tick;
    logic            step_en;
    logic [W-1:0]    up_sum;
    logic [W-1:0]    dn_diff;
    logic            up_hit;
    logic            dn_hit;
    logic [BITS-1:0] up_val;
    logic [BITS-1:0] dn_val;

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    // estop blocks acceptance so a coincident target cannot survive into FAULT
    assign accept  = tgt_valid & tgt_ready & ~estop;
    assign step_en = tick & ~accept;

    // Step arithmetic carried one bit wider so neither direction can wrap
    always_comb begin
        tgt_clamped = (W'(tgt_duty) > W'(DMAX)) ? DMAX : tgt_duty;
        up_sum      = W'(duty_cycle) + W'(STEP);
        up_hit      = (up_sum >= W'(target_q));
        up_val      = up_hit ? target_q : up_sum[BITS-1:0];
        dn_diff     = W'(duty_cycle) - W'(target_q);
        dn_hit      = (duty_cycle <= target_q) || (dn_diff <= W'(STEP));
        dn_val      = dn_hit ? target_q : (duty_cycle - BITS'(STEP));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (estop) begin
            state_nxt = ST_FAULT;
        end else if (accept) begin
            if (tgt_clamped > duty_cycle) begin
                state_nxt = ST_UP;
            end else if (tgt_clamped < duty_cycle) begin
                state_nxt = ST_DOWN;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_UP: begin
                    if (step_en && up_hit) state_nxt = ST_IDLE;
                end
                ST_DOWN: begin
                    if (step_en && dn_hit) state_nxt = ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clr) state_nxt = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tgt_ready = 1'b1;
        busy      = 1'b0;
        at_target = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_IDLE:  at_target = 1'b1;
            ST_UP:    busy      = 1'b1;
            ST_DOWN:  busy      = 1'b1;
            ST_FAULT: begin
                fault     = 1'b1;
                tgt_ready = 1'b0;
            end
            default: ;
        endcase
    end

    // Duty only moves on a tick; estop zeroes both duty and the stored target
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_cycle <= '0;
            target_q   <= '0;
        end else if (estop) begin
            duty_cycle <= '0;
            target_q   <= '0;
        end else begin
            if (accept) begin
                target_q <= tgt_clamped;
            end
            if (step_en && (state_q == ST_UP)) begin
                duty_cycle <= up_val;
            end else if (step_en && (state_q == ST_DOWN)) begin
                duty_cycle <= dn_val;
            end
        end
    end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl: a slow instance (TICK_DIV=4, STEP=1) and a
// fast instance (TICK_DIV=1, STEP=7) share one clock.
module tb_duty_ramp_ctrl;

    logic       clk;
    logic       reset;

    logic       a_valid, a_ready, a_estop, a_fclr, a_busy, a_at, a_fault;
    logic [7:0] a_tgt, a_duty;
    logic       b_valid, b_ready, b_estop, b_fclr, b_busy, b_at, b_fault;
    logic [7:0] b_tgt, b_duty;

    int n_assert = 0;
    int n_fail   = 0;

    duty_ramp_ctrl #(.BITS(8), .DUTY_MAX(250), .STEP(1), .TICK_DIV(4)) u_slow (
        .clk(clk), .reset(reset), .tgt_valid(a_valid), .tgt_ready(a_ready),
        .tgt_duty(a_tgt), .estop(a_estop), .fault_clr(a_fclr), .duty_cycle(a_duty),
        .busy(a_busy), .at_target(a_at), .fault(a_fault)
    );

    duty_ramp_ctrl #(.BITS(8), .DUTY_MAX(250), .STEP(7), .TICK_DIV(1)) u_fast (
        .clk(clk), .reset(reset), .tgt_valid(b_valid), .tgt_ready(b_ready),
        .tgt_duty(b_tgt), .estop(b_estop), .fault_clr(b_fclr), .duty_cycle(b_duty),
        .busy(b_busy), .at_target(b_at), .fault(b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_duty(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_tgt = 8'd0; a_estop = 1'b0; a_fclr = 1'b0;
        b_valid = 1'b0; b_tgt = 8'd0; b_estop = 1'b0; b_fclr = 1'b0;

        // Reset state
        cyc(2);
        chk_duty("rst_duty", a_duty, 8'd0);
        chk_bit("rst_ready", a_ready, 1'b1);
        chk_bit("rst_at", a_at, 1'b1);
        chk_bit("rst_busy", a_busy, 1'b0);
        chk_bit("rst_fault", a_fault, 1'b0);
        chk_duty("rst_duty_b", b_duty, 8'd0);
        chk_bit("rst_at_b", b_at, 1'b1);
        reset = 1'b0;
        cyc(3);

        // Ramp up 0 -> 10, one step every 4 cycles
        a_valid = 1'b1; a_tgt = 8'd10;
        cyc(1);
        a_valid = 1'b0;
        chk_bit("up_busy", a_busy, 1'b1);
        chk_duty("up_no_step_on_accept", a_duty, 8'd0);
        for (int k = 1; k <= 10; k++) begin
            cyc(3);
            chk_duty("up_hold", a_duty, 8'(k - 1));
            cyc(1);
            chk_duty("up_step", a_duty, 8'(k));
        end
        chk_bit("up_at_target", a_at, 1'b1);
        chk_bit("up_busy_done", a_busy, 1'b0);
        cyc(12);
        chk_duty("idle_hold", a_duty, 8'd10);

        // Retarget: head for 100, switch to 20 once duty reaches 40
        a_valid = 1'b1; a_tgt = 8'd100;
        cyc(1);
        a_valid = 1'b0;
        cyc(120);
        chk_duty("rt_reach40", a_duty, 8'd40);
        a_valid = 1'b1; a_tgt = 8'd20;
        cyc(1);
        a_valid = 1'b0;
        chk_bit("rt_busy", a_busy, 1'b1);
        chk_duty("rt_no_step", a_duty, 8'd40);
        cyc(4);
        chk_duty("rt_first_down", a_duty, 8'd39);
        cyc(75);
        chk_duty("rt_before_end", a_duty, 8'd21);
        chk_bit("rt_busy_before_end", a_busy, 1'b1);
        cyc(1);
        chk_duty("rt_end", a_duty, 8'd20);
        chk_bit("rt_at_target", a_at, 1'b1);

        // Estop mid-ramp at duty 60, with a target offered at the same time
        a_valid = 1'b1; a_tgt = 8'd100;
        cyc(1);
        a_valid = 1'b0;
        cyc(160);
        chk_duty("es_reach60", a_duty, 8'd60);
        chk_bit("es_busy_pre", a_busy, 1'b1);
        a_estop = 1'b1; a_valid = 1'b1; a_tgt = 8'd200;
        cyc(1);
        chk_duty("es_duty0", a_duty, 8'd0);
        chk_bit("es_fault", a_fault, 1'b1);
        chk_bit("es_ready0", a_ready, 1'b0);
        chk_bit("es_busy0", a_busy, 1'b0);
        a_valid = 1'b0; a_fclr = 1'b1;
        cyc(1);
        chk_bit("es_clr_blocked", a_fault, 1'b1);
        a_estop = 1'b0;
        cyc(1);
        chk_bit("es_cleared", a_fault, 1'b0);
        chk_bit("es_at_target", a_at, 1'b1);
        chk_duty("es_duty_stays0", a_duty, 8'd0);
        chk_bit("es_ready1", a_ready, 1'b1);
        a_fclr = 1'b0;
        cyc(10);
        chk_duty("es_idle_zero", a_duty, 8'd0);

        // Reset beats estop and an active ramp; lingering estop faults afterwards
        a_valid = 1'b1; a_tgt = 8'd50;
        cyc(1);
        a_valid = 1'b0;
        cyc(8);
        chk_duty("rs_ramp2", a_duty, 8'd2);
        reset = 1'b1; a_estop = 1'b1;
        cyc(1);
        chk_bit("rs_fault_low", a_fault, 1'b0);
        chk_bit("rs_at", a_at, 1'b1);
        chk_duty("rs_duty0", a_duty, 8'd0);
        reset = 1'b0;
        cyc(1);
        chk_bit("rs_estop_fault", a_fault, 1'b1);
        a_estop = 1'b0; a_fclr = 1'b1;
        cyc(1);
        a_fclr = 1'b0;
        chk_bit("rs_fault_exit", a_fault, 1'b0);

        // Clamp: 255 requested, ceiling 250, step 7 each cycle
        b_valid = 1'b1; b_tgt = 8'd255;
        cyc(1);
        b_valid = 1'b0;
        chk_duty("cl_no_step", b_duty, 8'd0);
        chk_bit("cl_busy", b_busy, 1'b1);
        for (int k = 1; k <= 35; k++) begin
            cyc(1);
            chk_duty("cl_step", b_duty, 8'(7 * k));
            chk_bit("cl_le_max", (b_duty <= 8'd250), 1'b1);
        end
        cyc(1);
        chk_duty("cl_final", b_duty, 8'd250);
        chk_bit("cl_at_target", b_at, 1'b1);
        cyc(5);
        chk_duty("cl_hold", b_duty, 8'd250);

        // Down 250 -> 5 lands exactly, then 5 -> 0 must not wrap
        b_valid = 1'b1; b_tgt = 8'd5;
        cyc(1);
        b_valid = 1'b0;
        cyc(34);
        chk_duty("uf_pre", b_duty, 8'd12);
        cyc(1);
        chk_duty("uf_at5", b_duty, 8'd5);
        chk_bit("uf_at5_idle", b_at, 1'b1);
        b_valid = 1'b1; b_tgt = 8'd0;
        cyc(1);
        b_valid = 1'b0;
        chk_duty("uf_accept_hold", b_duty, 8'd5);
        chk_bit("uf_down", b_busy, 1'b1);
        cyc(1);
        chk_duty("uf_zero", b_duty, 8'd0);
        chk_bit("uf_idle", b_at, 1'b1);
        cyc(3);
        chk_duty("uf_no_wrap", b_duty, 8'd0);

        // Small target below one step: single tick lands on target
        b_valid = 1'b1; b_tgt = 8'd3;
        cyc(1);
        b_valid = 1'b0;
        cyc(1);
        chk_duty("small_up", b_duty, 8'd3);
        chk_bit("small_idle", b_at, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
